// File: rtl/iccm_loader_pkg.sv
// rtl/iccm_loader_pkg.sv - shared types and constants for the ICCM image loader
package iccm_loader_pkg;

  typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, CSUM, DONE, ERR} ldr_state_e;

  localparam int LenBytes     = 2;
  localparam int DefDataWidth = 32;
  localparam int BytesPerWord = DefDataWidth / 8;

endpackage

// File: rtl/iccm_word_packer.sv
// rtl/iccm_word_packer.sv - little-endian byte-to-word assembler with a one-cycle word_valid pulse
module iccm_word_packer
  import iccm_loader_pkg::*;
#(
  parameter int DataWidth = DefDataWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_byte_valid,
  input  logic [7:0]           i_byte,
  output logic                 o_last_lane,
  output logic                 o_word_valid,
  output logic [DataWidth-1:0] o_word
);

  localparam int Lanes = DataWidth / 8;
  localparam int IdxW  = (Lanes > 1) ? $clog2(Lanes) : 1;

  logic [IdxW-1:0]      r_idx;
  logic [DataWidth-1:0] r_word;
  logic                 r_word_valid;

  assign o_last_lane  = (r_idx == IdxW'(Lanes - 1));
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

  // The word stays stable during the valid cycle even if a new byte lands in lane 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idx        <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= i_byte_valid && o_last_lane;
      if (i_byte_valid) begin
        r_word[{r_idx, 3'b000} +: 8] <= i_byte;
        r_idx                        <= o_last_lane ? '0 : r_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/iccm_loader.sv
// rtl/iccm_loader.sv - parses a length/payload/checksum byte stream and writes words into the ICCM
module iccm_loader
  import iccm_loader_pkg::*;
#(
  parameter int AddrWidth = 11,
  parameter int DataWidth = DefDataWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_valid_i,
  input  logic [7:0]           rx_data_i,
  output logic                 rx_ready_o,
  output logic                 iccm_we_o,
  output logic [AddrWidth-1:0] iccm_waddr_o,
  output logic [DataWidth-1:0] iccm_wdata_o,
  output logic [DataWidth-1:0] iccm_wmask_o,
  output logic                 load_done_o,
  output logic                 len_err_o,
  output logic                 csum_err_o,
  output logic [AddrWidth:0]   words_o
);

  localparam int LenW = LenBytes * 8;
  localparam int CmpW = LenW + 1;
  localparam logic [CmpW-1:0] Depth = CmpW'(1) << AddrWidth;

  ldr_state_e           r_state, w_next;
  logic [LenW-1:0]      r_len;
  logic [7:0]           r_csum;
  logic                 r_csum_err;
  logic [AddrWidth:0]   r_words;
  logic [AddrWidth-1:0] r_waddr;

  logic                 w_xfer, w_byte_valid, w_last_lane, w_word_valid, w_last_word;
  logic [DataWidth-1:0] w_word;
  logic [LenW-1:0]      w_len_hdr;

  assign rx_ready_o   = !rst_i && (r_state inside {HDR_LO, HDR_HI, DATA, CSUM});
  assign w_xfer       = rx_valid_i && rx_ready_o;
  assign w_byte_valid = w_xfer && (r_state == DATA);
  assign w_len_hdr    = {rx_data_i, r_len[7:0]};
  // Written-word count lags the 4th byte, so at that byte r_words is this word's index.
  assign w_last_word  = (CmpW'(r_words) + CmpW'(1)) == {1'b0, r_len};

  iccm_word_packer #(.DataWidth(DataWidth)) u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_byte_valid(w_byte_valid),
    .i_byte      (rx_data_i),
    .o_last_lane (w_last_lane),
    .o_word_valid(w_word_valid),
    .o_word      (w_word)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= HDR_LO;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      HDR_LO: if (w_xfer) w_next = HDR_HI;
      HDR_HI: begin
        if (w_xfer) begin
          if ({1'b0, w_len_hdr} > Depth) w_next = ERR;
          else if (w_len_hdr == '0)      w_next = CSUM;
          else                           w_next = DATA;
        end
      end
      DATA:    if (w_byte_valid && w_last_lane && w_last_word) w_next = CSUM;
      CSUM:    if (w_xfer) w_next = DONE;
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_len      <= '0;
      r_csum     <= '0;
      r_csum_err <= 1'b0;
      r_words    <= '0;
      r_waddr    <= '0;
    end else begin
      if (w_xfer && r_state == HDR_LO) r_len[7:0]      <= rx_data_i;
      if (w_xfer && r_state == HDR_HI) r_len[LenW-1:8] <= rx_data_i;
      if (w_xfer && (r_state inside {HDR_LO, HDR_HI, DATA})) r_csum <= r_csum ^ rx_data_i;
      if (w_xfer && r_state == CSUM && rx_data_i != r_csum) r_csum_err <= 1'b1;
      if (w_byte_valid && w_last_lane) r_waddr <= r_words[AddrWidth-1:0];
      if (w_word_valid) r_words <= r_words + 1'b1;
    end
  end

  assign iccm_we_o    = w_word_valid;
  assign iccm_waddr_o = r_waddr;
  assign iccm_wdata_o = w_word_valid ? w_word : '0;
  assign iccm_wmask_o = w_word_valid ? '1 : '0;
  assign load_done_o  = (r_state == DONE);
  assign len_err_o    = (r_state == ERR);
  assign csum_err_o   = r_csum_err;
  assign words_o      = r_words;

endmodule

// File: tb/tb_iccm_loader.sv
// tb/tb_iccm_loader.sv - directed self-checking bench for iccm_loader
module tb_iccm_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        iccm_we_o;
  logic [10:0] iccm_waddr_o;
  logic [31:0] iccm_wdata_o;
  logic [31:0] iccm_wmask_o;
  logic        load_done_o;
  logic        len_err_o;
  logic        csum_err_o;
  logic [11:0] words_o;

  iccm_loader #(.AddrWidth(11), .DataWidth(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .rx_ready_o  (rx_ready_o),
    .iccm_we_o   (iccm_we_o),
    .iccm_waddr_o(iccm_waddr_o),
    .iccm_wdata_o(iccm_wdata_o),
    .iccm_wmask_o(iccm_wmask_o),
    .load_done_o (load_done_o),
    .len_err_o   (len_err_o),
    .csum_err_o  (csum_err_o),
    .words_o     (words_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cyc = -1;
  int t_last   = 0;
  logic [7:0] csum = 8'h00;

  logic [10:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [31:0] q_mask[$];
  int          q_cyc[$];
  logic [31:0] exp_words[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (iccm_we_o) begin
      q_addr.push_back(iccm_waddr_o);
      q_data.push_back(iccm_wdata_o);
      q_mask.push_back(iccm_wmask_o);
      q_cyc.push_back(cyc);
    end
    if (load_done_o && done_cyc < 0) done_cyc = cyc;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] qa(input int i);
    return (i < q_addr.size()) ? 64'(q_addr[i]) : 'x;
  endfunction
  function automatic logic [63:0] qd(input int i);
    return (i < q_data.size()) ? 64'(q_data[i]) : 'x;
  endfunction
  function automatic logic [63:0] qm(input int i);
    return (i < q_mask.size()) ? 64'(q_mask[i]) : 'x;
  endfunction
  function automatic logic [63:0] qc(input int i);
    return (i < q_cyc.size()) ? 64'(q_cyc[i]) : 'x;
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk_i);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(posedge clk_i);
    #1;
    t_last     = cyc;
    csum       = csum ^ b;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i      = 1'b1;
    rx_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_ready", 64'(rx_ready_o), 0);
    check("rst_done", 64'(load_done_o), 0);
    check("rst_csum_err", 64'(csum_err_o), 0);
    check("rst_len_err", 64'(len_err_o), 0);
    check("rst_words", 64'(words_o), 0);
    rst_i = 1'b0;
    q_addr.delete(); q_data.delete(); q_mask.delete(); q_cyc.delete();
    exp_words.delete();
    done_cyc = -1;
    csum     = 8'h00;
  endtask

  task automatic two_word_stream(input logic bad_csum, input string pfx);
    int tp, tc;
    send(8'h02); send(8'h00);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    tp = t_last;
    if (bad_csum) send(8'h00);
    else          send(csum);
    tc = t_last;
    repeat (3) @(negedge clk_i);
    check({pfx, "_nwrites"}, 64'(q_addr.size()), 2);
    check({pfx, "_addr0"}, qa(0), 0);
    check({pfx, "_data0"}, qd(0), 64'h12345678);
    check({pfx, "_mask0"}, qm(0), 64'hFFFFFFFF);
    check({pfx, "_addr1"}, qa(1), 1);
    check({pfx, "_data1"}, qd(1), 64'hDEADBEEF);
    check({pfx, "_mask1"}, qm(1), 64'hFFFFFFFF);
    check({pfx, "_we_latency"}, qc(1), 64'(tp));
    check({pfx, "_done_latency"}, 64'(done_cyc), 64'(tc));
    check({pfx, "_done"}, 64'(load_done_o), 1);
    check({pfx, "_csum_err"}, 64'(csum_err_o), 64'(bad_csum));
    check({pfx, "_words"}, 64'(words_o), 2);
    check({pfx, "_ready"}, 64'(rx_ready_o), 0);
    check({pfx, "_idle_wdata"}, 64'(iccm_wdata_o), 0);
    check({pfx, "_idle_waddr"}, 64'(iccm_waddr_o), 1);
  endtask

  initial begin
    int tc;
    rst_i      = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("reset_ready_low", 64'(rx_ready_o), 0);
    check("reset_we", 64'(iccm_we_o), 0);
    check("reset_waddr", 64'(iccm_waddr_o), 0);
    check("reset_wdata", 64'(iccm_wdata_o), 0);
    check("reset_wmask", 64'(iccm_wmask_o), 0);
    check("reset_flags", 64'({load_done_o, len_err_o, csum_err_o}), 0);
    check("reset_words", 64'(words_o), 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_reset_ready", 64'(rx_ready_o), 1);

    // Good two-word image (checksum 0x28 = XOR of all preceding bytes)
    two_word_stream(1'b0, "good");

    // Same image, wrong checksum; the following reset must clear the sticky error
    do_reset();
    two_word_stream(1'b1, "badcs");

    // Length one past depth
    do_reset();
    send(8'h01); send(8'h08);
    send(8'h5A);
    repeat (4) @(negedge clk_i);
    check("len_err", 64'(len_err_o), 1);
    check("len_ready", 64'(rx_ready_o), 0);
    check("len_done", 64'(load_done_o), 0);
    check("len_nwrites", 64'(q_addr.size()), 0);

    // Full depth, random payload, back-to-back bytes
    do_reset();
    send(8'h00); send(8'h08);
    for (int i = 0; i < 2048; i++) begin
      logic [31:0] w;
      w = $urandom();
      exp_words.push_back(w);
      send_word(w);
    end
    send(csum);
    repeat (3) @(negedge clk_i);
    check("full_nwrites", 64'(q_addr.size()), 2048);
    for (int i = 0; i < 2048; i++) begin
      check($sformatf("full_addr%0d", i), qa(i), 64'(i));
      check($sformatf("full_data%0d", i), qd(i), 64'(exp_words[i]));
    end
    check("full_last_before_done", 64'(qc(2047) < 64'(done_cyc)), 1);
    check("full_done", 64'(load_done_o), 1);
    check("full_csum_err", 64'(csum_err_o), 0);
    check("full_words", 64'(words_o), 2048);

    // Empty image
    do_reset();
    send(8'h00); send(8'h00);
    send(8'h00);
    tc = t_last;
    repeat (3) @(negedge clk_i);
    check("empty_nwrites", 64'(q_addr.size()), 0);
    check("empty_done_latency", 64'(done_cyc), 64'(tc));
    check("empty_csum_err", 64'(csum_err_o), 0);
    check("empty_words", 64'(words_o), 0);

    // Abort mid-load, then a fresh one-word image
    do_reset();
    send(8'h03); send(8'h00);
    send_word(32'h11223344);
    send(8'h55);
    repeat (2) @(negedge clk_i);
    check("abort_prewrite", 64'(q_addr.size()), 1);
    do_reset();
    send(8'h01); send(8'h00);
    send_word(32'hDDCCBBAA);
    send(csum);
    repeat (3) @(negedge clk_i);
    check("abort_nwrites", 64'(q_addr.size()), 1);
    check("abort_addr0", qa(0), 0);
    check("abort_data0", qd(0), 64'hDDCCBBAA);
    check("abort_words", 64'(words_o), 1);
    check("abort_done", 64'(load_done_o), 1);
    check("abort_csum_err", 64'(csum_err_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
